seq_signed_divider: RTL and testbench

- Multi-cycle signed two's-complement divider; inverse of the combinational Booth multiplier used in the ALU datapath.
- Computes quotient and remainder of dividend/divisor using restoring division on magnitudes, one quotient bit per clock.
- Uses a start/busy/done handshake so the CISC control unit can stall the execute stage for DIV/MOD instructions.

---
 rtl/seq_signed_divider.sv | 137 +++++++++++++
 tb/tb_seq_signed_divider.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient
// bit per clock, with the sign fix-up applied in a final cycle.
module seq_signed_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] qs_q, qs_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic             aneg_q, aneg_d, bneg_q, bneg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic             done_q, done_d, dz_q, dz_d, ov_q, ov_d;

    logic [WIDTH-1:0] amag_in, bmag_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    assign amag_in = dividend[WIDTH-1] ? '0 - dividend : dividend;
    assign bmag_in = divisor[WIDTH-1]  ? '0 - divisor  : divisor;
    // R < |divisor| always, so R fits WIDTH bits; only the shifted value needs WIDTH+1.
    assign shifted = {r_q, qs_q[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, bmag_q};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        qs_d    = qs_q;
        bmag_d  = bmag_q;
        aneg_d  = aneg_q;
        bneg_d  = bneg_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    aneg_d  = dividend[WIDTH-1];
                    bneg_d  = divisor[WIDTH-1];
                    qs_d    = amag_in;
                    bmag_d  = bmag_in;
                    r_d     = '0;
                    // Divide-by-zero spends a single idle CALC cycle so done lands two edges out.
                    cnt_d   = (divisor == '0) ? CW'(1) : CW'(WIDTH);
                    state_d = CALC;
                end
            end
            CALC: begin
                if (bmag_q != '0) begin
                    if (!diff[WIDTH+1]) begin
                        r_d  = diff[WIDTH-1:0];
                        qs_d = {qs_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_d  = shifted[WIDTH-1:0];
                        qs_d = {qs_q[WIDTH-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (bmag_q == '0) begin
                    // qs still holds |dividend|; re-sign it to return the dividend.
                    quot_d = '1;
                    rem_d  = aneg_q ? '0 - qs_q : qs_q;
                    dz_d   = 1'b1;
                    ov_d   = 1'b0;
                end else begin
                    quot_d = (aneg_q ^ bneg_q) ? '0 - qs_q : qs_q;
                    rem_d  = aneg_q ? '0 - r_q : r_q;
                    dz_d   = 1'b0;
                    ov_d   = aneg_q & bneg_q & (bmag_q == WIDTH'(1)) & (qs_q == MIN_MAG);
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            qs_q    <= '0;
            bmag_q  <= '0;
            aneg_q  <= 1'b0;
            bneg_q  <= 1'b0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            qs_q    <= qs_d;
            bmag_q  <= bmag_d;
            aneg_q  <= aneg_d;
            bneg_q  <= bneg_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider (WIDTH=4): directed vectors push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_seq_signed_divider;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = '0, divisor = '0;
    logic [3:0] quotient, remainder;
    logic       busy, done, div_by_zero, overflow;

    seq_signed_divider #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ov;
        int         lat;
        int         t0;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Caller is away from the posedge; returns just after the sampling edge.
    task automatic issue(input string name, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er, input logic edz,
                         input logic eov, input int lat, input bit track);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (track) begin
            e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.lat = lat; e.t0 = cyc; e.name = name;
            sbq.push_back(e);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sbq.size() != 0 || busy) && n < 100);
        if (n >= 100) chk("wait_idle_timeout", 32'(sbq.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, "_quot"}, 32'(quotient), 32'(e.q));
                chk({e.name, "_rem"}, 32'(remainder), 32'(e.r));
                chk({e.name, "_dz"}, 32'(div_by_zero), 32'(e.dz));
                chk({e.name, "_ov"}, 32'(overflow), 32'(e.ov));
                chk({e.name, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
                chk({e.name, "_busy_at_done"}, 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        int bc;
        int n;
        int dn;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_rem", 32'(remainder), 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 7/2 with busy-width measurement
        issue("p7d2", 4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0, 5, 1'b1);
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
            if (busy) bc++;
        end
        chk("p7d2_busy_cycles", 32'(bc), 32'd5);
        wait_idle();

        issue("m7d2", 4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 1'b0, 5, 1'b1);
        wait_idle();
        issue("p7dm2", 4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0, 5, 1'b1);
        wait_idle();
        issue("m8dm1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b1, 5, 1'b1);
        wait_idle();
        issue("m8d1", 4'b1000, 4'b0001, 4'b1000, 4'b0000, 1'b0, 1'b0, 5, 1'b1);
        wait_idle();
        issue("p3d7", 4'b0011, 4'b0111, 4'b0000, 4'b0011, 1'b0, 1'b0, 5, 1'b1);
        wait_idle();
        issue("m1dm8", 4'b1111, 4'b1000, 4'b0000, 4'b1111, 1'b0, 1'b0, 5, 1'b1);
        wait_idle();
        issue("p5d0", 4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1, 1'b0, 2, 1'b1);
        wait_idle();
        issue("m8d0", 4'b1000, 4'b0000, 4'b1111, 4'b1000, 1'b1, 1'b0, 2, 1'b1);
        wait_idle();

        // start while busy is ignored; start in the done cycle is accepted
        issue("p6d3", 4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0, 1'b0, 5, 1'b1);
        @(negedge clk);
        dividend = 4'b0111;
        divisor  = 4'b0001;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 4'b0000;
        divisor  = 4'b0000;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("p6d3_done_timeout", 32'd1, 32'd0);
        issue("m6d4", 4'b1010, 4'b0100, 4'b1111, 4'b1110, 1'b0, 1'b0, 5, 1'b1);
        wait_idle();

        // reset mid-operation
        issue("abort", 4'b0111, 4'b0010, 4'b0, 4'b0, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_quot", 32'(quotient), 32'd0);
        chk("midrst_rem", 32'(remainder), 32'd0);
        chk("midrst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("midrst_no_done", 32'(dn), 32'd0);
        issue("p7d2_after_rst", 4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 1'b0, 5, 1'b1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
